fetch_redirect_unit: RTL and testbench

// IF-stage PC owner and consumer of the EX-stage redirect interface (take_branch/next_pc/flush_pipe).

---
 rtl/fetch_redirect_unit_pkg.sv | 24 ++
 rtl/fetch_redirect_unit_hold_buf.sv | 50 +++++
 rtl/fetch_redirect_unit.sv | 215 +++++++++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Contents:
//   RESET_PC_DEFAULT  - default first fetch address after reset
//   NOP_INSTR_DEFAULT - addi x0,x0,0, used to fill an empty IF/ID register
//   fetch_state_e     - fetch FSM state encoding (IDLE, REQ, WAIT, HOLD, DROP)
//   align_word()      - clears the two low address bits of a byte address
package fetch_redirect_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,  // leaving reset, nothing issued yet
    FS_REQ  = 3'd1,  // request presented, waiting for ready
    FS_WAIT = 3'd2,  // request accepted, waiting for the response
    FS_HOLD = 3'd3,  // response parked in the hold buffer while IF/ID is stalled
    FS_DROP = 3'd4   // response in flight belongs to a redirected-away path
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_hold_buf.sv
// One-entry {pc, instr} buffer that parks a fetched instruction while the
// IF/ID register is stalled.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (clears valid only)
//   load_i     - capture pc_i/instr_i and mark the entry valid
//   clear_i    - empty the entry (wins over load_i)
//   pc_i       - PC of the instruction being parked
//   instr_i    - instruction word being parked
//   valid_o    - entry holds an instruction
//   pc_o       - parked PC
//   instr_o    - parked instruction
module fetch_redirect_unit_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  // Payload is only meaningful while valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_i && !clear_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC owner. Issues one-outstanding instruction-memory requests,
// consumes EX-stage redirects, discards responses belonging to a
// redirected-away path and drives the IF/ID pipeline register.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   redirect_valid_i   - taken branch from EX, load redirect_pc_i
//   redirect_pc_i      - branch target (low two bits ignored, flagged)
//   flush_pipe_i       - kill IF/ID contents
//   stall_if_i         - hold IF/ID and PC
//   imem_req_valid_o   - fetch request
//   imem_req_ready_i   - request accepted when valid & ready
//   imem_req_addr_o    - word-aligned fetch address
//   imem_rsp_valid_i   - response for the outstanding request
//   imem_rsp_data_i    - instruction word
//   ifid_valid_o       - IF/ID holds a live instruction
//   ifid_pc_o          - PC of ifid_instr_o
//   ifid_instr_o       - instruction (NOP when empty)
//   misalign_err_o     - one-cycle pulse after a redirect to a non-word address
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        flush_pipe_i,
  input  logic        stall_if_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        misalign_err_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         req_valid_q;
  logic [31:0]  req_addr_q;
  logic         drop_pending_q;
  logic         ifid_valid_q;
  logic [31:0]  ifid_pc_q;
  logic [31:0]  ifid_instr_q;
  logic         misalign_q;

  logic [31:0]  pc_inc_d;
  logic [31:0]  redir_pc_d;
  logic         accept;
  logic         rsp_seen;
  logic         hb_load;
  logic         hb_clear;
  logic         hb_valid;
  logic [31:0]  hb_pc;
  logic [31:0]  hb_instr;

  assign accept     = req_valid_q & imem_req_ready_i;
  assign pc_inc_d   = pc_q + 32'd4;  // wraps naturally at 2^32
  assign redir_pc_d = align_word(redirect_pc_i);
  // A response only counts in the two states that have one outstanding.
  assign rsp_seen   = imem_rsp_valid_i & ((state_q == FS_WAIT) | (state_q == FS_DROP));

  assign hb_load  = (state_q == FS_WAIT) & imem_rsp_valid_i & stall_if_i & ~redirect_valid_i;
  assign hb_clear = redirect_valid_i | ((state_q == FS_HOLD) & ~stall_if_i);

  fetch_redirect_unit_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hb_load),
    .clear_i (hb_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rsp_data_i),
    .valid_o (hb_valid),
    .pc_o    (hb_pc),
    .instr_o (hb_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FS_IDLE;
      pc_q           <= RESET_PC;
      req_valid_q    <= 1'b0;
      req_addr_q     <= RESET_PC;
      drop_pending_q <= 1'b0;
      ifid_valid_q   <= 1'b0;
      ifid_pc_q      <= 32'd0;
      ifid_instr_q   <= NOP_INSTR;
      misalign_q     <= 1'b0;
    end else begin
      misalign_q <= redirect_valid_i & (|redirect_pc_i[1:0]);

      // IF/ID default: killed on redirect/flush, bubble when free-running,
      // unchanged while stalled. Deliveries below override the bubble.
      if (redirect_valid_i || flush_pipe_i) begin
        ifid_valid_q <= 1'b0;
        ifid_pc_q    <= 32'd0;
        ifid_instr_q <= NOP_INSTR;
      end else if (!stall_if_i) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
      end

      if (redirect_valid_i) begin
        pc_q <= redir_pc_d;
        unique case (state_q)
          FS_IDLE, FS_HOLD: begin
            state_q     <= FS_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= redir_pc_d;
          end
          FS_REQ: begin
            // A presented request may not be withdrawn or altered; remember
            // that its response must be thrown away once it is accepted.
            if (accept) begin
              state_q     <= FS_DROP;
              req_valid_q <= 1'b0;
            end else begin
              drop_pending_q <= 1'b1;
            end
          end
          FS_WAIT: begin
            if (imem_rsp_valid_i) begin
              state_q     <= FS_REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= redir_pc_d;
            end else begin
              state_q <= FS_DROP;
            end
          end
          FS_DROP: begin
            // Stale response arriving with a newer redirect: discard it and
            // go straight to the newest target.
            if (imem_rsp_valid_i) begin
              state_q        <= FS_REQ;
              req_valid_q    <= 1'b1;
              req_addr_q     <= redir_pc_d;
              drop_pending_q <= 1'b0;
            end
          end
          default: state_q <= FS_IDLE;
        endcase
      end else begin
        unique case (state_q)
          FS_IDLE: begin
            state_q     <= FS_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= pc_q;
          end
          FS_REQ: begin
            if (accept) begin
              req_valid_q <= 1'b0;
              state_q     <= drop_pending_q ? FS_DROP : FS_WAIT;
            end
          end
          FS_WAIT: begin
            if (rsp_seen) begin
              if (stall_if_i) begin
                state_q <= FS_HOLD;
              end else begin
                if (!flush_pipe_i) begin
                  ifid_valid_q <= 1'b1;
                  ifid_pc_q    <= pc_q;
                  ifid_instr_q <= imem_rsp_data_i;
                end
                pc_q        <= pc_inc_d;
                state_q     <= FS_REQ;
                req_valid_q <= 1'b1;
                req_addr_q  <= pc_inc_d;
              end
            end
          end
          FS_HOLD: begin
            if (!stall_if_i && hb_valid) begin
              if (!flush_pipe_i) begin
                ifid_valid_q <= 1'b1;
                ifid_pc_q    <= hb_pc;
                ifid_instr_q <= hb_instr;
              end
              pc_q        <= pc_inc_d;
              state_q     <= FS_REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= pc_inc_d;
            end
          end
          FS_DROP: begin
            if (rsp_seen) begin
              drop_pending_q <= 1'b0;
              state_q        <= FS_REQ;
              req_valid_q    <= 1'b1;
              req_addr_q     <= pc_q;
            end
          end
          default: state_q <= FS_IDLE;
        endcase
      end
    end
  end

  // imem must only answer while a request is outstanding.
  rsp_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid_i |-> ((state_q == FS_WAIT) || (state_q == FS_DROP)));

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = req_addr_q;
  assign ifid_valid_o     = ifid_valid_q;
  assign ifid_pc_o        = ifid_pc_q;
  assign ifid_instr_o     = ifid_instr_q;
  assign misalign_err_o   = misalign_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios followed by a randomized
// run, every cycle checked against a transaction-level reference model.
module tb_fetch_redirect_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid, flush_pipe, stall_if;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ifid_valid, misalign_err;
  logic [31:0] ifid_pc, ifid_instr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_redirect_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .flush_pipe_i     (flush_pipe),
    .stall_if_i       (stall_if),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .ifid_valid_o     (ifid_valid),
    .ifid_pc_o        (ifid_pc),
    .ifid_instr_o     (ifid_instr),
    .misalign_err_o   (misalign_err)
  );

  // Reference model: fetch described as transactions in flight.
  bit          m_started;   // first request issued since reset
  bit          m_req;       // request presented, not yet accepted
  bit          m_out;       // accepted request awaiting its response
  bit          m_stale;     // the awaited response belongs to an abandoned path
  bit          m_kill;      // presented request already abandoned by a redirect
  bit          m_buf_v;     // fetched instruction parked during a stall
  logic [31:0] m_pc, m_addr, m_infl, m_buf_pc, m_buf_ins;
  bit          e_valid, e_mis, e_pc_chk;
  logic [31:0] e_pc, e_ins;
  int          rsp_wait, lat;
  bit          rand_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_req = 0; m_out = 0; m_stale = 0; m_kill = 0; m_buf_v = 0;
    m_pc = RPC; m_addr = RPC; m_infl = RPC;
    e_valid = 0; e_pc = 32'd0; e_ins = NOP; e_mis = 0; e_pc_chk = 1;
    rsp_wait = 0;
  endtask

  task automatic start_rsp();
    rsp_wait = (rand_lat ? int'($urandom_range(1, 3)) : lat) - 1;
  endtask

  task automatic check_outputs();
    check1("req_valid", {31'd0, imem_req_valid}, {31'd0, m_req});
    check1("req_addr", imem_req_addr, m_addr);
    check1("ifid_valid", {31'd0, ifid_valid}, {31'd0, e_valid});
    check1("ifid_instr", ifid_instr, e_ins);
    if (e_pc_chk) check1("ifid_pc", ifid_pc, e_pc);
    check1("misalign_err", {31'd0, misalign_err}, {31'd0, e_mis});
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit          acc, rsp, deliver, was_hold;
    logic [31:0] tgt, dpc, dins;
    acc      = m_req && imem_req_ready;
    rsp      = imem_rsp_valid;
    deliver  = 0;
    dpc      = 32'd0;
    dins     = NOP;
    was_hold = m_buf_v;
    e_mis    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      tgt = {redirect_pc[31:2], 2'b00};
      m_buf_v = 0;
      if (!m_started || was_hold) begin
        m_started = 1; m_req = 1; m_addr = tgt;
      end else if (m_req) begin
        if (acc) begin
          m_req = 0; m_out = 1; m_stale = 1; m_kill = 0; m_infl = m_addr; start_rsp();
        end else begin
          m_kill = 1;
        end
      end else if (m_out) begin
        if (rsp) begin
          m_out = 0; m_stale = 0; m_req = 1; m_addr = tgt;
        end else begin
          m_stale = 1;
        end
      end
      m_pc = tgt;
      e_valid = 0; e_pc = 32'd0; e_ins = NOP; e_pc_chk = 1;
    end else begin
      if (!m_started) begin
        m_started = 1; m_req = 1; m_addr = m_pc;
      end else if (m_req) begin
        if (acc) begin
          m_req = 0; m_out = 1; m_stale = m_kill; m_kill = 0; m_infl = m_addr; start_rsp();
        end
      end else if (m_out) begin
        if (rsp) begin
          m_out = 0;
          if (m_stale) begin
            m_stale = 0; m_req = 1; m_addr = m_pc;
          end else if (stall_if) begin
            m_buf_v = 1; m_buf_pc = m_pc; m_buf_ins = imem_rsp_data;
          end else begin
            deliver = 1; dpc = m_pc; dins = imem_rsp_data;
            m_pc = m_pc + 32'd4; m_req = 1; m_addr = m_pc;
          end
        end
      end else if (m_buf_v && !stall_if) begin
        deliver = 1; dpc = m_buf_pc; dins = m_buf_ins; m_buf_v = 0;
        m_pc = m_pc + 32'd4; m_req = 1; m_addr = m_pc;
      end
      if (flush_pipe) begin
        e_valid = 0; e_pc = 32'd0; e_ins = NOP; e_pc_chk = 1;
      end else if (deliver) begin
        e_valid = 1; e_pc = dpc; e_ins = dins; e_pc_chk = 1;
      end else if (!stall_if) begin
        e_valid = 0; e_ins = NOP; e_pc_chk = 0;
      end
    end
  endtask

  // One clock: imem answers from the model's view of the outstanding request.
  task automatic cyc();
    if (m_out && rsp_wait == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m_infl);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (m_out) rsp_wait--;
    end
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    redirect_valid = 1'b0;
    flush_pipe     = 1'b0;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_valid = 1'b1;
    flush_pipe     = 1'b1;
    redirect_pc    = a;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; flush_pipe = 1'b0; stall_if = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    lat = 1; rand_lat = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Straight-line fetch, ready always high, one-cycle response.
    imem_req_ready = 1'b1;
    repeat (8) cyc();

    // Stall while a response lands: instruction parked, released later.
    for (int i = 0; i < 20 && !(m_out && rsp_wait == 0); i++) cyc();
    check1("sync_stall", {31'd0, m_out}, 32'd1);
    stall_if = 1'b1;
    repeat (3) cyc();
    stall_if = 1'b0;
    repeat (4) cyc();

    // Redirect while the response is still two cycles away.
    lat = 3;
    for (int i = 0; i < 20 && !(m_out && rsp_wait >= 1); i++) cyc();
    check1("sync_wait", {31'd0, m_out}, 32'd1);
    redir(32'h0000_0100);
    repeat (8) cyc();

    // Redirect in the same cycle as the response.
    lat = 2;
    for (int i = 0; i < 20 && !(m_out && rsp_wait == 0 && !m_stale); i++) cyc();
    check1("sync_same", {31'd0, m_out}, 32'd1);
    redir(32'h0000_0100);
    repeat (6) cyc();

    // Redirect while a request is held off by ready=0.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && !m_req; i++) cyc();
    check1("sync_req", {31'd0, m_req}, 32'd1);
    redir(32'h0000_0200);
    cyc();
    imem_req_ready = 1'b1;
    repeat (10) cyc();

    // Misaligned targets and PC wrap at the top of the address space.
    lat = 1;
    redir(32'h0000_0102);
    repeat (6) cyc();
    redir(32'hFFFF_FFFE);
    repeat (8) cyc();

    // Flush without redirect.
    repeat (2) begin
      flush_pipe = 1'b1;
      cyc();
      repeat (3) cyc();
    end

    // Randomized traffic.
    rand_lat = 1;
    repeat (400) begin
      int r;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall_if       = ($urandom_range(0, 4) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        redirect_valid = 1'b1;
        flush_pipe     = 1'b1;
        redirect_pc    = $urandom;
      end else if (r < 8) begin
        flush_pipe = 1'b1;
      end
      cyc();
    end

    // Reset in the middle of traffic, then restart.
    stall_if = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
